// File: rtl/testram_pkg.sv
// Shared types and helpers for the testram_dp dual-port test RAM.
// State encoding for the clear sequencer, lane-count and parity helpers.
package testram_pkg;

   typedef enum logic {
      StClear = 1'b0,
      StIdle  = 1'b1
   } state_e;

   function automatic int unsigned lane_count(input int unsigned dwidth);
      return dwidth / 8;
   endfunction

   // Even parity: the stored bit makes the 9-bit lane have an even number of ones.
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/testram_clrseq.sv
// Clear sequencer for testram_dp: walks every address once after reset or on request.
// BUSY is high for exactly 2**AWIDTH cycles, one write per cycle.
module testram_clrseq
   import testram_pkg::*;
#(
   parameter int unsigned AWIDTH = 10
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              clr_i,
   output logic              busy_o,
   output logic              clr_we_o,
   output logic [AWIDTH-1:0] clr_addr_o
);

   localparam logic [AWIDTH-1:0] LastAddr = '1;

   state_e            state_q, state_d;
   logic [AWIDTH-1:0] cnt_q, cnt_d;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= StClear;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy_o   = 1'b0;
      clr_we_o = 1'b0;
      unique case (state_q)
         StClear: begin
            busy_o   = 1'b1;
            clr_we_o = 1'b1;
            if (cnt_q == LastAddr) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StIdle: begin
            if (clr_i) begin
               state_d = StClear;
               cnt_d   = '0;
            end
         end
      endcase
   end

   assign clr_addr_o = cnt_q;

endmodule

// File: rtl/testram_dp.sv
// Single-clock dual-port test RAM with byte enables, selectable read-during-write and a
// hardware clear sequencer. Optional per-lane even parity under TESTRAM_PARITY_EN.
module testram_dp
   import testram_pkg::*;
#(
   parameter int unsigned AWIDTH   = 10,
   parameter int unsigned DWIDTH   = 32,
   parameter int unsigned RDW_MODE = 0,
   parameter logic [7:0]  CLRVAL   = 8'h00
) (
   input  logic                          CLK,
   input  logic                          RSTN,
   input  logic                          CLR,
   output logic                          BUSY,
   input  logic                          WE,
   input  logic [lane_count(DWIDTH)-1:0] WBE,
   input  logic [AWIDTH-1:0]             WADDR,
   input  logic [DWIDTH-1:0]             WDATA,
   input  logic                          RE,
   input  logic [AWIDTH-1:0]             RADDR,
   output logic [DWIDTH-1:0]             RDATA,
   output logic                          RVALID
`ifdef TESTRAM_PARITY_EN
   ,
   input  logic                          PINJ,
   output logic                          PERR
`endif
);

   localparam int unsigned NB    = lane_count(DWIDTH);
   localparam int unsigned DEPTH = 2 ** AWIDTH;
`ifdef TESTRAM_PARITY_EN
   localparam int unsigned LW    = 9;
`else
   localparam int unsigned LW    = 8;
`endif
   localparam int unsigned MW    = NB * LW;

   logic              busy;
   logic              clr_we;
   logic [AWIDTH-1:0] clr_addr;
   logic              user_ok;
   logic              rd_en;

   logic              mem_we;
   logic [AWIDTH-1:0] mem_addr;
   logic [NB-1:0]     mem_be;
   logic [MW-1:0]     wr_word;
   logic [MW-1:0]     rd_word;
   logic [DWIDTH-1:0] rd_data;

   logic [MW-1:0]     mem [DEPTH];

   logic [DWIDTH-1:0] rdata_q;
   logic              rvalid_q;

   testram_clrseq #(
      .AWIDTH (AWIDTH)
   ) u_clrseq (
      .CLK        (CLK),
      .RSTN       (RSTN),
      .clr_i      (CLR),
      .busy_o     (busy),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );

   // A CLR request in IDLE swallows any user access in the same cycle.
   assign user_ok = ~busy & ~CLR;
   assign rd_en   = RE & user_ok;

   always_comb begin
      mem_we   = clr_we | (WE & user_ok);
      mem_addr = clr_we ? clr_addr : WADDR;
      mem_be   = clr_we ? '1 : WBE;
      wr_word  = '0;
      for (int i = 0; i < NB; i++) begin
         wr_word[i*LW +: 8] = clr_we ? CLRVAL : WDATA[i*8 +: 8];
`ifdef TESTRAM_PARITY_EN
         wr_word[i*LW+8] = clr_we ? even_parity(CLRVAL)
                                  : (even_parity(WDATA[i*8 +: 8]) ^ PINJ);
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_be[i]) begin
               mem[mem_addr][i*LW +: LW] <= wr_word[i*LW +: LW];
            end
         end
      end
   end

   // Array read sees pre-edge contents; bypass substitutes the enabled lanes of the write.
   always_comb begin
      rd_word = mem[RADDR];
      if ((RDW_MODE != 0) && WE && user_ok && (WADDR == RADDR)) begin
         for (int i = 0; i < NB; i++) begin
            if (WBE[i]) begin
               rd_word[i*LW +: LW] = wr_word[i*LW +: LW];
            end
         end
      end
      rd_data = '0;
      for (int i = 0; i < NB; i++) begin
         rd_data[i*8 +: 8] = rd_word[i*LW +: 8];
      end
   end

`ifdef TESTRAM_PARITY_EN
   logic rd_perr;
   logic perr_q;

   always_comb begin
      rd_perr = 1'b0;
      for (int i = 0; i < NB; i++) begin
         rd_perr = rd_perr | (even_parity(rd_word[i*LW +: 8]) ^ rd_word[i*LW+8]);
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= rd_en & rd_perr;
      end
   end

   assign PERR = perr_q;
`endif

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= rd_en;
         if (rd_en) begin
            rdata_q <= rd_data;
         end
      end
   end

   assign RDATA  = rdata_q;
   assign RVALID = rvalid_q;
   assign BUSY   = busy;

endmodule

// File: tb/tb_testram_dp.sv
// Self-checking bench for testram_dp: two instances (old-data and bypass read-during-write)
// share stimulus and are checked against a word/lane array model.
module tb_testram_dp;

   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 32;
   localparam int unsigned NB    = 4;
   localparam int unsigned DEPTH = 16;

   logic          CLK = 1'b0;
   logic          RSTN;
   logic          CLR;
   logic          WE;
   logic          RE;
   logic [NB-1:0] WBE;
   logic [AW-1:0] WADDR;
   logic [AW-1:0] RADDR;
   logic [DW-1:0] WDATA;
   logic          busy0, busy1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
`ifdef TESTRAM_PARITY_EN
   logic          PINJ;
   logic          perr0, perr1;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: one word and one "bad parity" lane mask per address.
   logic [DW-1:0] ref_mem [DEPTH];
   logic [NB-1:0] ref_bad [DEPTH];
   logic [DW-1:0] exp0, exp1;
   logic          exp_valid;
   logic          exp_perr0, exp_perr1;

   always #5 CLK = ~CLK;

   testram_dp #(.AWIDTH(AW), .DWIDTH(DW), .RDW_MODE(0), .CLRVAL(8'h00)) u_dut0 (
      .CLK    (CLK),
      .RSTN   (RSTN),
      .CLR    (CLR),
      .BUSY   (busy0),
      .WE     (WE),
      .WBE    (WBE),
      .WADDR  (WADDR),
      .WDATA  (WDATA),
      .RE     (RE),
      .RADDR  (RADDR),
      .RDATA  (rdata0),
`ifdef TESTRAM_PARITY_EN
      .PINJ   (PINJ),
      .PERR   (perr0),
`endif
      .RVALID (rvalid0)
   );

   testram_dp #(.AWIDTH(AW), .DWIDTH(DW), .RDW_MODE(1), .CLRVAL(8'h00)) u_dut1 (
      .CLK    (CLK),
      .RSTN   (RSTN),
      .CLR    (CLR),
      .BUSY   (busy1),
      .WE     (WE),
      .WBE    (WBE),
      .WADDR  (WADDR),
      .WDATA  (WDATA),
      .RE     (RE),
      .RADDR  (RADDR),
      .RDATA  (rdata1),
`ifdef TESTRAM_PARITY_EN
      .PINJ   (PINJ),
      .PERR   (perr1),
`endif
      .RVALID (rvalid1)
   );

   task automatic idle_inputs();
      CLR = 1'b0; WE = 1'b0; RE = 1'b0; WBE = '0; WADDR = '0; RADDR = '0; WDATA = '0;
`ifdef TESTRAM_PARITY_EN
      PINJ = 1'b0;
`endif
   endtask

   task automatic model_clear();
      for (int a = 0; a < DEPTH; a++) begin
         ref_mem[a] = '0;
         ref_bad[a] = '0;
      end
   endtask

   // One accepted IDLE cycle: drive, update the model, step past the edge, release inputs.
   task automatic cycle(input logic we, input logic [NB-1:0] wbe, input logic [AW-1:0] waddr,
                        input logic [DW-1:0] wdata, input logic re, input logic [AW-1:0] raddr,
                        input logic pinj);
      logic [DW-1:0] old_w, new_w;
      logic [NB-1:0] old_b, new_b;
      @(negedge CLK);
      WE = we; WBE = wbe; WADDR = waddr; WDATA = wdata; RE = re; RADDR = raddr;
`ifdef TESTRAM_PARITY_EN
      PINJ = pinj;
`endif
      old_w = ref_mem[raddr];
      old_b = ref_bad[raddr];
      new_w = old_w;
      new_b = old_b;
      if (we && waddr == raddr) begin
         for (int i = 0; i < NB; i++) begin
            if (wbe[i]) begin
               new_w[i*8 +: 8] = wdata[i*8 +: 8];
               new_b[i]        = pinj;
            end
         end
      end
      exp_valid = re;
      exp_perr0 = re && (old_b != 0);
      exp_perr1 = re && (new_b != 0);
      if (re) begin
         exp0 = old_w;
         exp1 = new_w;
      end
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (wbe[i]) begin
               ref_mem[waddr][i*8 +: 8] = wdata[i*8 +: 8];
               ref_bad[waddr][i]        = pinj;
            end
         end
      end
      @(posedge CLK);
      #1;
      idle_inputs();
   endtask

   // Counts edges until BUSY drops; returns 999 if it never does.
   task automatic wait_busy_low(output int n);
      n = 0;
      while (n < 200) begin
         @(posedge CLK);
         #1;
         n++;
         if (!busy0) return;
      end
      n = 999;
   endtask

   task automatic test_reset();
      int n;
      int bad_valid;
      RSTN = 1'b1;
      idle_inputs();
      #2 RSTN = 1'b0;
      #2;
      checks++;
      if ({busy0, rvalid0, rdata0} !== {1'b1, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset_state0 got busy=%b rvalid=%b rdata=%h exp 1 0 0", busy0, rvalid0,
                  rdata0);
      end
      checks++;
      if ({busy1, rvalid1, rdata1} !== {1'b1, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset_state1 got busy=%b rvalid=%b rdata=%h exp 1 0 0", busy1, rvalid1,
                  rdata1);
      end
      exp0 = '0; exp1 = '0;
      @(negedge CLK);
      @(negedge CLK);
      RSTN = 1'b1;
      // Accesses during the clear must be ignored.
      WE = 1'b1; WBE = '1; WADDR = 4'd5; WDATA = $urandom; RE = 1'b1; RADDR = 4'd5;
      n = 0;
      bad_valid = 0;
      while (n < 200) begin
         @(posedge CLK);
         #1;
         n++;
         if (rvalid0 || rvalid1) bad_valid++;
         if (!busy0) break;
      end
      idle_inputs();
      model_clear();
      checks++;
      if (n !== 16) begin
         errors++;
         $display("FAIL reset_busy_len got %0d cycles exp 16", n);
      end
      checks++;
      if (bad_valid !== 0) begin
         errors++;
         $display("FAIL busy_rvalid got %0d valid cycles exp 0", bad_valid);
      end
      checks++;
      if (busy1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy1 got %b exp 0", busy1);
      end
      for (int a = 0; a < DEPTH; a++) begin
         cycle(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
         checks++;
         if ({rvalid0, rdata0, rvalid1, rdata1} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL clear_read a=%0d got %b/%h %b/%h exp 1/0", a, rvalid0, rdata0,
                     rvalid1, rdata1);
         end
      end
      cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
      checks++;
      if ({rvalid0, rvalid1} !== 2'b00) begin
         errors++;
         $display("FAIL rvalid_drop got %b%b exp 00", rvalid0, rvalid1);
      end
   endtask

   task automatic test_byte_enable();
      cycle(1'b1, 4'hF, 4'd3, 32'hFFFF_FFFF, 1'b0, '0, 1'b0);
      cycle(1'b1, 4'b0101, 4'd3, 32'hA5A5_1234, 1'b0, '0, 1'b0);
      cycle(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
      checks++;
      if (rdata0 !== 32'hFFA5_FF34 || rdata1 !== 32'hFFA5_FF34) begin
         errors++;
         $display("FAIL byte_enable got %h/%h exp ffa5ff34", rdata0, rdata1);
      end
      cycle(1'b1, 4'b0000, 4'd3, 32'h0, 1'b0, '0, 1'b0);
      cycle(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
      checks++;
      if (rdata0 !== 32'hFFA5_FF34 || rdata1 !== 32'hFFA5_FF34) begin
         errors++;
         $display("FAIL wbe_zero got %h/%h exp ffa5ff34", rdata0, rdata1);
      end
   endtask

   task automatic test_rdw();
      logic [DW-1:0] r;
      cycle(1'b1, 4'hF, 4'd7, 32'h1, 1'b0, '0, 1'b0);
      cycle(1'b1, 4'hF, 4'd7, 32'h2, 1'b1, 4'd7, 1'b0);
      checks++;
      if (rdata0 !== 32'h1) begin
         errors++;
         $display("FAIL rdw_old got %h exp 00000001", rdata0);
      end
      checks++;
      if (rdata1 !== 32'h2) begin
         errors++;
         $display("FAIL rdw_new got %h exp 00000002", rdata1);
      end
      cycle(1'b1, 4'b0011, 4'd7, 32'hAAAA_BBBB, 1'b1, 4'd7, 1'b0);
      checks++;
      if (rdata0 !== 32'h2 || rdata1 !== 32'h0000_BBBB) begin
         errors++;
         $display("FAIL rdw_partial got %h/%h exp 00000002/0000bbbb", rdata0, rdata1);
      end
      r = $urandom;
      cycle(1'b1, 4'hF, 4'd8, r, 1'b1, 4'd7, 1'b0);
      checks++;
      if (rdata0 !== 32'h0000_BBBB || rdata1 !== 32'h0000_BBBB) begin
         errors++;
         $display("FAIL rdw_diff_addr got %h/%h exp 0000bbbb", rdata0, rdata1);
      end
   endtask

   task automatic test_random();
      logic          we, re, pj;
      logic [NB-1:0] wbe;
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd;
      for (int k = 0; k < 300; k++) begin
         we  = 1'($urandom_range(0, 1));
         re  = 1'($urandom_range(0, 1));
         wbe = 4'($urandom);
         wa  = 4'($urandom);
         ra  = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
         wd  = $urandom;
`ifdef TESTRAM_PARITY_EN
         pj  = ($urandom_range(0, 7) == 0);
`else
         pj  = 1'b0;
`endif
         cycle(we, wbe, wa, wd, re, ra, pj);
         checks++;
         if (rvalid0 !== exp_valid || rvalid1 !== exp_valid) begin
            errors++;
            $display("FAIL rand_rvalid k=%0d got %b/%b exp %b", k, rvalid0, rvalid1, exp_valid);
         end
         checks++;
         if (rdata0 !== exp0) begin
            errors++;
            $display("FAIL rand_rdata0 k=%0d got %h exp %h", k, rdata0, exp0);
         end
         checks++;
         if (rdata1 !== exp1) begin
            errors++;
            $display("FAIL rand_rdata1 k=%0d got %h exp %h", k, rdata1, exp1);
         end
`ifdef TESTRAM_PARITY_EN
         checks++;
         if (perr0 !== exp_perr0 || perr1 !== exp_perr1) begin
            errors++;
            $display("FAIL rand_perr k=%0d got %b/%b exp %b/%b", k, perr0, perr1, exp_perr0,
                     exp_perr1);
         end
`endif
      end
   endtask

   task automatic test_clr();
      int n;
      for (int a = 0; a < DEPTH; a++) cycle(1'b1, 4'hF, AW'(a), $urandom, 1'b0, '0, 1'b0);
      @(negedge CLK);
      CLR = 1'b1; WE = 1'b1; WBE = 4'hF; WADDR = 4'd2; WDATA = 32'hDEAD_BEEF;
      RE = 1'b1; RADDR = 4'd2;
      @(posedge CLK);
      #1;
      idle_inputs();
      checks++;
      if (busy0 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== exp0) begin
         errors++;
         $display("FAIL clr_start got busy=%b rvalid=%b rdata=%h exp 1 0 %h", busy0, rvalid0,
                  rdata0, exp0);
      end
      wait_busy_low(n);
      model_clear();
      checks++;
      if (n !== 16) begin
         errors++;
         $display("FAIL clr_busy_len got %0d cycles exp 16", n);
      end
      for (int a = 0; a < DEPTH; a++) begin
         cycle(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
         checks++;
         if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL clr_read a=%0d got %h/%h exp 0", a, rdata0, rdata1);
         end
      end
   endtask

   task automatic test_reset_midclear();
      int n;
      for (int a = 0; a < DEPTH; a++) cycle(1'b1, 4'hF, AW'(a), $urandom | 32'h1, 1'b0, '0, 1'b0);
      // Reset with a read in flight drops RVALID at once.
      cycle(1'b0, '0, '0, '0, 1'b1, 4'd4, 1'b0);
      #1 RSTN = 1'b0;
      #1;
      checks++;
      if (rvalid0 !== 1'b0 || rdata0 !== 32'h0 || busy0 !== 1'b1) begin
         errors++;
         $display("FAIL reset_midread got rvalid=%b rdata=%h busy=%b exp 0 0 1", rvalid0, rdata0,
                  busy0);
      end
      exp0 = '0; exp1 = '0;
      @(negedge CLK);
      RSTN = 1'b1;
      wait_busy_low(n);
      for (int a = 0; a < DEPTH; a++) cycle(1'b1, 4'hF, AW'(a), $urandom | 32'h1, 1'b0, '0, 1'b0);
      @(negedge CLK);
      CLR = 1'b1;
      @(posedge CLK);
      #1;
      idle_inputs();
      for (int k = 0; k < 9; k++) begin
         @(posedge CLK);
         #1;
      end
      RSTN = 1'b0;
      #2;
      checks++;
      if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
         errors++;
         $display("FAIL reset_midclear_busy got %b/%b exp 1", busy0, busy1);
      end
      @(negedge CLK);
      @(negedge CLK);
      RSTN = 1'b1;
      wait_busy_low(n);
      model_clear();
      checks++;
      if (n !== 16) begin
         errors++;
         $display("FAIL reset_midclear_len got %0d cycles exp 16", n);
      end
      for (int a = 0; a < DEPTH; a++) begin
         cycle(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
         checks++;
         if (rdata0 !== 32'h0) begin
            errors++;
            $display("FAIL midclear_read a=%0d got %h exp 0", a, rdata0);
         end
      end
   endtask

`ifdef TESTRAM_PARITY_EN
   task automatic test_parity();
      cycle(1'b1, 4'hF, 4'd4, $urandom, 1'b0, '0, 1'b0);
      cycle(1'b1, 4'b0010, 4'd4, $urandom, 1'b0, '0, 1'b1);
      cycle(1'b0, '0, '0, '0, 1'b1, 4'd4, 1'b0);
      checks++;
      if (perr0 !== 1'b1 || perr1 !== 1'b1) begin
         errors++;
         $display("FAIL perr_inject got %b/%b exp 1", perr0, perr1);
      end
      cycle(1'b1, 4'hF, 4'd4, $urandom, 1'b0, '0, 1'b0);
      cycle(1'b0, '0, '0, '0, 1'b1, 4'd4, 1'b0);
      checks++;
      if (perr0 !== 1'b0 || perr1 !== 1'b0) begin
         errors++;
         $display("FAIL perr_rewrite got %b/%b exp 0", perr0, perr1);
      end
      cycle(1'b1, 4'b0001, 4'd4, $urandom, 1'b1, 4'd4, 1'b1);
      checks++;
      if (perr0 !== 1'b0 || perr1 !== 1'b1) begin
         errors++;
         $display("FAIL perr_bypass got %b/%b exp 0/1", perr0, perr1);
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_byte_enable();
      test_rdw();
      test_random();
      test_clr();
      test_reset_midclear();
`ifdef TESTRAM_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/testram_dp.md
# testram_dp

Parametrised single-clock dual-port test RAM with per-byte write enables, selectable read-during-write behaviour, and a hardware clear sequencer that zeroes the array after reset or on request. It replaces the fixed 8-bit simulation RAM used by the MAC test benches and FIFOs. Initialisation is explicit, cycle-accurate and observable through `BUSY`. No simulation-time array zeroing is required.

## Interface
- `AWIDTH`, 10, address width; depth = 2**AWIDTH words.
- `DWIDTH`, 32, data width; must be a multiple of 8; NB = DWIDTH/8 byte lanes.
- `RDW_MODE`, 0, same-address read-during-write: 0 = old data, 1 = new (bypassed) data.
- `CLRVAL`, 8'h00, byte value written to every lane by the clear sequencer.

Ports:
- `CLK`, in, 1, single clock; all logic on the rising edge.
- `RSTN`, in, 1, reset; asynchronous, active-low.
- `CLR`, in, 1, one-cycle request to re-run the clear sequence; honoured only when `BUSY` = 0.
- `BUSY`, out, 1, clear sequence in progress.
- `WE`, in, 1, write request.
- `WBE`, in, NB, byte-lane write enables; lane i = `WDATA[8i+7:8i]`.
- `WADDR`, in, AWIDTH, write address.
- `WDATA`, in, DWIDTH, write data.
- `RE`, in, 1, read request.
- `RADDR`, in, AWIDTH, read address.
- `RDATA`, out, DWIDTH, read data.
- `RVALID`, out, 1, `RDATA` updated this cycle.
- `PINJ`, in, 1, parity error inject. Present only with `TESTRAM_PARITY_EN`.
- `PERR`, out, 1, parity error on the current read. Present only with `TESTRAM_PARITY_EN`.

## Operation
- State machine has two states: CLEAR and IDLE.
- Reset (`RSTN` = 0) forces the following, asynchronously:
  - state = CLEAR, clear counter = 0.
  - `BUSY` = 1, `RDATA` = 0, `RVALID` = 0, `PERR` = 0.
- Array contents are not reset.
- CLEAR state:
  - Each cycle, write `CLRVAL` to all lanes at the counter address, then increment the counter.
  - At counter = 2**AWIDTH-1, write that address and go to IDLE.
  - `WE`, `RE` and `CLR` are ignored; `RVALID` stays 0.
- IDLE state:
  - `CLR` = 1 → go to CLEAR with counter = 0. Any `WE`/`RE` in the same cycle is dropped.
- Write: when `WE` = 1 in IDLE, lanes with `WBE[i]` = 1 are updated. Lanes with `WBE[i]` = 0 keep their contents. `WBE` = 0 performs no write.
- Read: when `RE` = 1 in IDLE, `RDATA` is loaded with the word at `RADDR`. When `RE` = 0, `RDATA` holds its previous value.
- Simultaneous read and write to the same address:
  - `RDW_MODE` = 0: the pre-write word is returned.
  - `RDW_MODE` = 1: enabled lanes return `WDATA` and disabled lanes return stored data.
  - Different addresses: fully independent.
- Reset asserted mid-clear or mid-read: the clear restarts from address 0 and any pending `RVALID` is lost.

## Timing
- Read latency is 1 cycle. `RE` sampled at edge N gives `RDATA` and `RVALID` = 1 after edge N; `RVALID` deasserts after edge N+1 unless `RE` is held.
- Back-to-back reads sustain one word per cycle. Writes are zero-latency and visible to a read issued on the next cycle.
- The clear takes exactly 2**AWIDTH cycles from the first rising edge after `RSTN` deasserts (or after the `CLR` edge). `BUSY` falls after the edge that writes the last address.
- The first access is accepted in the first cycle `BUSY` = 0.

## Configuration
- Macro: `TESTRAM_PARITY_EN`.
- Defined:
  - Each byte lane stores an extra even-parity bit, so array width = DWIDTH+NB.
  - When `PINJ` = 1 during a write, the stored parity of the enabled lanes is inverted.
  - On a read, `PERR` = 1 with `RVALID` if any lane's parity mismatches; otherwise `PERR` = 0.
  - The clear sequencer writes correct parity.
  - In `RDW_MODE` = 1 bypass, parity is checked on the bypassed data including injection.
- Undefined: array width = DWIDTH; `PINJ` and `PERR` ports are absent.

## Structure
- Package `testram_pkg` holds:
  - the state enum (CLEAR, IDLE);
  - a function for byte-lane count;
  - a function for even parity of a byte.
- Sub-module `testram_clrseq` holds the clear FSM plus address counter, and outputs `BUSY`, clear-write enable and clear address. The top level muxes the clear path against the user write port.

## Test plan
- Release reset with AWIDTH=4 → `BUSY` high for exactly 16 cycles; read all 16 addresses → all 0 with one `RVALID` per `RE`.
- Write 32'hA5A5_1234 to address 3 with `WBE` = 4'b0101 over 32'hFFFF_FFFF → read returns 32'hFFA5_FF34.
- Same-cycle `WE`/`RE` at address 7 (old 32'h1, new 32'h2) → returns 32'h1 with `RDW_MODE` = 0 and 32'h2 with `RDW_MODE` = 1.
- Pulse `CLR` with `WE` asserted in the same cycle → write dropped, `BUSY` = 1 for 2**AWIDTH cycles, memory all 0 afterwards.
- Assert `RSTN` low at clear counter = 9 → `BUSY` stays high and the full 2**AWIDTH-cycle clear restarts from address 0 after release.
- With `TESTRAM_PARITY_EN`: write with `PINJ` = 1, `WBE` = 4'b0010 → read gives `PERR` = 1; rewrite without `PINJ` → `PERR` = 0.
